// File: rtl/tb_ctrl_pkg.sv
// Shared constants and types for the testbench-control responder: address map,
// pass/fail magic values, region decode and the registered response bundle.
package tb_ctrl_pkg;

  localparam logic [31:0] ADDR_STDOUT = 32'h1000_0000;
  localparam logic [31:0] ADDR_STATUS = 32'h2000_0000;
  localparam logic [31:0] ADDR_EXIT   = 32'h2000_0004;
  localparam logic [31:0] ADDR_ALARM  = 32'h2000_0008;
  localparam logic [31:0] ADDR_CYCLE  = 32'h1500_1000;

  localparam logic [31:0] MAGIC_PASS = 32'd123456789;
  localparam logic [31:0] MAGIC_FAIL = 32'd1;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_STDOUT,
    REG_STATUS,
    REG_EXIT,
    REG_CYCLE,
    REG_ALARM
  } region_e;

  typedef struct packed {
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  // Word-granular decode; byte-offset bits never reach this function.
  function automatic region_e decode(input logic [31:2] word_addr);
    region_e r;
    case (word_addr)
      ADDR_STDOUT[31:2]: r = REG_STDOUT;
      ADDR_STATUS[31:2]: r = REG_STATUS;
      ADDR_EXIT[31:2]:   r = REG_EXIT;
      ADDR_ALARM[31:2]:  r = REG_ALARM;
      ADDR_CYCLE[31:2]:  r = REG_CYCLE;
      default:           r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tb_ctrl_char_fifo.sv
// Power-of-two character FIFO feeding the stdout stream; pointers wrap
// naturally and an occupancy counter provides full/empty.
module tb_ctrl_char_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // NOTE: storage is deliberately not reset; the occupancy count alone decides
  // what is valid, so clearing it discards the contents without a wide reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tb_ctrl_responder.sv
// Memory-mapped simulation control slave: stdout FIFO, sticky pass/fail flags,
// exit code and cycle counter. Define TB_CTRL_ALARM_EN to add the alarm input.
module tb_ctrl_responder
  import tb_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] CYCLE_RST  = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
`ifdef TB_CTRL_ALARM_EN
  input  logic        alarm_i,
`endif
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        char_valid_o,
  input  logic        char_ready_i,
  output logic [7:0]  char_o,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  region_e     region;
  logic        fifo_full, fifo_empty, push, pop;
  logic        acc_err, accept, wr;
  logic [31:0] rd_val;
  logic        passed_q, failed_q;
  logic [31:0] cycle_q;
  resp_t       resp_q;
  logic        unused_bits;

  assign unused_bits = ^{addr_i[1:0], be_i[3:1]};
  assign region      = decode(addr_i[31:2]);

  // Only a stdout write can stall, and only while the FIFO has no room.
  assign gnt_o  = req_i && !(we_i && (region == REG_STDOUT) && fifo_full);
  assign accept = gnt_o && !acc_err;
  assign wr     = accept && we_i;
  assign push   = wr && (region == REG_STDOUT) && be_i[0];
  assign pop    = !fifo_empty && char_ready_i;

`ifdef TB_CTRL_ALARM_EN
  logic alarm_q;
  assign tests_failed_o = failed_q | alarm_q;
`else
  assign tests_failed_o = failed_q;
`endif
  assign tests_passed_o = passed_q;

  // NOTE: every output of this block gets a default before the case so no
  // path through it can leave a latch behind.
  always_comb begin
    acc_err = 1'b0;
    rd_val  = '0;
    unique case (region)
      REG_STDOUT: acc_err = !we_i;
      REG_STATUS: rd_val  = {30'b0, tests_failed_o, tests_passed_o};
      REG_EXIT:   acc_err = !we_i;
      REG_CYCLE: begin
        acc_err = we_i;
        rd_val  = cycle_q;
      end
`ifdef TB_CTRL_ALARM_EN
      REG_ALARM: begin
        acc_err = we_i;
        rd_val  = {31'b0, alarm_q};
      end
`endif
      default:    acc_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      resp_q       <= '0;
      passed_q     <= 1'b0;
      failed_q     <= 1'b0;
      exit_valid_o <= 1'b0;
      exit_value_o <= '0;
      cycle_q      <= CYCLE_RST;
`ifdef TB_CTRL_ALARM_EN
      alarm_q      <= 1'b0;
`endif
    end else begin
      cycle_q       <= cycle_q + 32'd1;
      resp_q.rvalid <= gnt_o;
      resp_q.err    <= gnt_o && acc_err;
      resp_q.rdata  <= (accept && !we_i) ? rd_val : '0;
      exit_valid_o  <= wr && (region == REG_EXIT);
      if (wr && (region == REG_EXIT)) exit_value_o <= wdata_i;
      if (wr && (region == REG_STATUS)) begin
        if (wdata_i == MAGIC_PASS) passed_q <= 1'b1;
        if (wdata_i == MAGIC_FAIL) failed_q <= 1'b1;
      end
`ifdef TB_CTRL_ALARM_EN
      if (alarm_i) alarm_q <= 1'b1;
`endif
    end
  end

  assign rvalid_o = resp_q.rvalid;
  assign err_o    = resp_q.err;
  assign rdata_o  = resp_q.rdata;

  tb_ctrl_char_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_char_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (wdata_i[7:0]),
    .pop_i   (pop),
    .data_o  (char_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign char_valid_o = !fifo_empty;

endmodule

// File: doc/tb_ctrl_responder.md
TB_CTRL_RESPONDER -- requirements
Module: tb_ctrl_responder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, stdout character FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter CYCLE_RST, default 32'h0, cycle counter reset value.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk_i  in  1  clock; all state on rising edge.
REQ-005 rst_ni  in  1  synchronous active-low reset.
REQ-006 req_i / we_i  in  1 / 1  data bus request / write enable.
REQ-007 addr_i  in  32  word address; bits [1:0] ignored.
REQ-008 be_i  in  4  byte enables.
REQ-009 wdata_i  in  32  write data.
REQ-010 gnt_o  out  1  request accepted this cycle.
REQ-011 rvalid_o / err_o  out  1 / 1  response valid / unmapped access.
REQ-012 rdata_o  out  32  read data.
REQ-013 char_valid_o / char_ready_i / char_o  out / in / out  1 / 1 / 8  stdout character stream.
REQ-014 tests_passed_o / tests_failed_o  out  1 / 1  sticky test verdicts.
REQ-015 exit_valid_o / exit_value_o  out  1 / 32  exit pulse / exit code.

Function
REQ-016 Map: STDOUT 32'h1000_0000 (W), STATUS 32'h2000_0000 (R/W), EXIT 32'h2000_0004 (W), CYCLE 32'h1500_1000 (R); all other addresses unmapped.
REQ-017 gnt_o = req_i, except 0 when the request is a write to STDOUT and the FIFO is full.
REQ-018 Each granted request SHALL produce exactly one rvalid_o pulse on the next cycle; rvalid_o is never asserted without a preceding grant.
REQ-019 rdata_o SHALL be valid only with rvalid_o and is 0 otherwise.
REQ-020 err_o SHALL assert with rvalid_o for an unmapped access, a read of STDOUT/EXIT, or a write to CYCLE; such accesses have no side effects.
REQ-021 A granted STDOUT write with be_i[0]=1 SHALL push wdata_i[7:0]; with be_i[0]=0 it is acknowledged without a push.
REQ-022 char_valid_o = FIFO not empty; char_o = head entry; pop when char_valid_o && char_ready_i.
REQ-023 A simultaneous push and pop SHALL leave the occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-024 A STATUS write of 32'd123456789 SHALL set tests_passed_o, a write of 32'd1 SHALL set tests_failed_o, and any other value has no effect; both flags SHALL stay sticky until reset.
REQ-025 A STATUS read SHALL return {30'b0, tests_failed_o, tests_passed_o}.
REQ-026 A granted EXIT write SHALL register wdata_i into exit_value_o (held) and pulse exit_valid_o for exactly one cycle, on the same cycle as rvalid_o.
REQ-027 The 32-bit cycle counter SHALL increment every cycle out of reset and wrap 32'hFFFF_FFFF -> 0; a CYCLE read returns the value at grant.

Reset
REQ-028 With rst_ni=0 at a clock edge, SHALL clear: FIFO empty, all pointers 0, rvalid_o=0, err_o=0, rdata_o=0, flags 0, exit_valid_o=0, exit_value_o=0, counter=CYCLE_RST.
REQ-029 Reset mid-transaction SHALL drop any pending response (no rvalid_o after reset) and discard FIFO contents.

Configuration
REQ-030 Macro TB_CTRL_ALARM_EN: when defined, SHALL add input alarm_i (1 bit), latch it into sticky alarm_q, map ALARM 32'h2000_0008 (R) returning {31'b0, alarm_q}, and force tests_failed_o=1 while alarm_q=1.
REQ-031 When TB_CTRL_ALARM_EN is undefined, alarm_i SHALL be absent and ALARM SHALL be unmapped (err_o).

Structure
REQ-032 Package tb_ctrl_pkg SHALL hold the address constants, the pass/fail magic values, and a response struct typedef (rvalid, err, rdata).
REQ-033 The FIFO SHALL be sub-module tb_ctrl_char_fifo (push/pop/full/empty, parameter DEPTH).

Verification
REQ-034 Write 0x41,0x42 to STDOUT with char_ready_i=1 -> char_o 'A' then 'B' on consecutive valid cycles; two rvalid_o pulses, err_o=0.
REQ-035 char_ready_i=0, 5 STDOUT writes (FIFO_DEPTH=4) -> 4 grants, 5th gnt_o=0 until one pop, then granted.
REQ-036 STATUS write 123456789 then 7 then 1 -> passed=1 after 1st, unchanged after 2nd, failed=1 after 3rd; STATUS read returns 3.
REQ-037 EXIT write 0x2A -> exit_valid_o 1-cycle pulse, exit_value_o=0x2A held; read of 0x3000_0000 -> err_o=1, rdata_o=0.
REQ-038 CYCLE_RST=32'hFFFF_FFFE, read CYCLE at cycles 0 and 3 after reset -> 0xFFFF_FFFE then 0x1; reset asserted during a pending read -> no rvalid_o.
REQ-039 With TB_CTRL_ALARM_EN defined, pulse alarm_i once -> tests_failed_o=1 stays set; ALARM read returns 1.
